delta_rmw_ctrl: RTL and testbench

- Read-modify-write controller for one simple dual-port delta BRAM: write port A, read port B, fixed read latency.
- Accepts delta update requests of the form (addr, value) and accumulates each into the stored word with a saturating add.
- Detects RAW hazards on in-flight addresses and stalls the requester until the hazard clears.
- Provides an end-of-iteration sweep that streams every word out and clears it to zero. Sits between the update generator and the delta BRAM instance.

---
 rtl/delta_rmw_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_delta_rmw_ctrl.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/delta_rmw_ctrl.sv
// Read-modify-write controller for a simple dual-port delta BRAM.
// Saturating accumulate of updates, RAW stall, and a read-and-clear sweep.
module delta_rmw_ctrl #(
  parameter int DELTA_BRAM_AWIDTH = 15,
  parameter int DELTA_BRAM_DWIDTH = 36,
  parameter int RD_LAT = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         upd_valid,
  input  logic [DELTA_BRAM_AWIDTH-1:0] upd_addr,
  input  logic [DELTA_BRAM_DWIDTH-1:0] upd_value,
  output logic                         upd_ready,
  input  logic                         sweep_start,
  output logic                         sweep_busy,
  output logic                         sweep_done,
  output logic                         out_valid,
  output logic [DELTA_BRAM_AWIDTH-1:0] out_addr,
  output logic [DELTA_BRAM_DWIDTH-1:0] out_value,
  output logic                         bram_rd_en,
  output logic [DELTA_BRAM_AWIDTH-1:0] bram_rd_addr,
  input  logic [DELTA_BRAM_DWIDTH-1:0] bram_rd_data,
  output logic                         bram_wr_en,
  output logic [DELTA_BRAM_AWIDTH-1:0] bram_wr_addr,
  output logic [DELTA_BRAM_DWIDTH-1:0] bram_wr_data
);

  localparam int AW = DELTA_BRAM_AWIDTH;
  localparam int DW = DELTA_BRAM_DWIDTH;
  localparam int L  = RD_LAT - 1;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    SWEEP,
    FLUSH
  } state_t;

  typedef enum logic {
    K_UPD,
    K_SWEEP
  } kind_t;

  state_t          state;
  state_t          state_n;
  logic [AW-1:0]   cnt;
  logic [AW-1:0]   cnt_n;
  logic            hazard;
  logic            empty;
  logic            iss;
  logic [AW-1:0]   iss_addr;
  kind_t           iss_kind;
  logic            done_n;
  logic [DW:0]     sum;
  logic [DW-1:0]   sat;

  // Read-latency stages; the write stage is the bram_wr_* register itself.
  logic            p_vld  [RD_LAT];
  logic [AW-1:0]   p_addr [RD_LAT];
  kind_t           p_kind [RD_LAT];
  logic [DW-1:0]   p_val  [RD_LAT];
  kind_t           w_kind;

  always_comb begin
    hazard = 1'b0;
    empty  = !bram_wr_en;
    for (int i = 0; i < RD_LAT; i++) begin
      if (p_vld[i]) begin
        empty = 1'b0;
        if (p_addr[i] == upd_addr) begin
          hazard = 1'b1;
        end
      end
    end
    if (bram_wr_en && bram_wr_addr == upd_addr) begin
      hazard = 1'b1;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    upd_ready = 1'b0;
    iss       = 1'b0;
    iss_addr  = upd_addr;
    iss_kind  = K_UPD;
    done_n    = 1'b0;
    unique case (state)
      IDLE: begin
        if (sweep_start) begin
          state_n = DRAIN;
        end else begin
          upd_ready = !hazard;
          iss       = upd_valid && !hazard;
        end
      end
      DRAIN: begin
        if (empty) begin
          state_n = SWEEP;
          cnt_n   = '0;
        end
      end
      SWEEP: begin
        iss      = 1'b1;
        iss_addr = cnt;
        iss_kind = K_SWEEP;
        if (cnt == '1) begin
          state_n = FLUSH;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      FLUSH: begin
        if (empty) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bram_rd_en   = iss;
  assign bram_rd_addr = iss_addr;
  assign sweep_busy   = (state != IDLE);

  assign sum = {1'b0, bram_rd_data} + {1'b0, p_val[L]};
  assign sat = sum[DW] ? '1 : sum[DW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      sweep_done <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      sweep_done <= done_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        p_vld[i]  <= 1'b0;
        p_addr[i] <= '0;
        p_kind[i] <= K_UPD;
        p_val[i]  <= '0;
      end
    end else begin
      p_vld[0]  <= iss;
      p_addr[0] <= iss_addr;
      p_kind[0] <= iss_kind;
      p_val[0]  <= upd_value;
      for (int i = 1; i < RD_LAT; i++) begin
        p_vld[i]  <= p_vld[i-1];
        p_addr[i] <= p_addr[i-1];
        p_kind[i] <= p_kind[i-1];
        p_val[i]  <= p_val[i-1];
      end
    end
  end

  // Sweep entries write zero and expose the pre-clear word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bram_wr_en   <= 1'b0;
      bram_wr_addr <= '0;
      bram_wr_data <= '0;
      w_kind       <= K_UPD;
      out_valid    <= 1'b0;
      out_addr     <= '0;
      out_value    <= '0;
    end else begin
      bram_wr_en   <= p_vld[L];
      bram_wr_addr <= p_addr[L];
      bram_wr_data <= (p_kind[L] == K_SWEEP) ? '0 : sat;
      w_kind       <= p_kind[L];
      out_valid    <= p_vld[L] && (p_kind[L] == K_SWEEP);
      out_addr     <= p_addr[L];
      out_value    <= bram_rd_data;
    end
  end

endmodule

// File: tb/tb_delta_rmw_ctrl.sv
// Bench for delta_rmw_ctrl: BRAM model, scoreboard monitor,
// vector table, random updates, sweep and reset sequences.
module tb_delta_rmw_ctrl;

  localparam int AW    = 4;
  localparam int DW    = 36;
  localparam int RL    = 2;
  localparam int DEPTH = 1 << AW;
  localparam logic [DW-1:0] MAXV = {DW{1'b1}};

  logic          clk = 1'b0;
  logic          rst_n;
  logic          upd_valid;
  logic [AW-1:0] upd_addr;
  logic [DW-1:0] upd_value;
  logic          upd_ready;
  logic          sweep_start;
  logic          sweep_busy;
  logic          sweep_done;
  logic          out_valid;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_value;
  logic          bram_rd_en;
  logic [AW-1:0] bram_rd_addr;
  logic [DW-1:0] bram_rd_data;
  logic          bram_wr_en;
  logic [AW-1:0] bram_wr_addr;
  logic [DW-1:0] bram_wr_data;

  delta_rmw_ctrl #(
    .DELTA_BRAM_AWIDTH(AW),
    .DELTA_BRAM_DWIDTH(DW),
    .RD_LAT(RL)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .upd_valid(upd_valid),
    .upd_addr(upd_addr),
    .upd_value(upd_value),
    .upd_ready(upd_ready),
    .sweep_start(sweep_start),
    .sweep_busy(sweep_busy),
    .sweep_done(sweep_done),
    .out_valid(out_valid),
    .out_addr(out_addr),
    .out_value(out_value),
    .bram_rd_en(bram_rd_en),
    .bram_rd_addr(bram_rd_addr),
    .bram_rd_data(bram_rd_data),
    .bram_wr_en(bram_wr_en),
    .bram_wr_addr(bram_wr_addr),
    .bram_wr_data(bram_wr_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // BRAM model with backdoor preload/clear ports for the bench.
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rq  [RL];
  logic          pre_en = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;
  logic          clr = 1'b0;

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end
    if (pre_en) mem[pre_addr] <= pre_data;
    if (bram_wr_en) mem[bram_wr_addr] <= bram_wr_data;
    rq[0] <= bram_rd_en ? mem[bram_rd_addr] : '0;
    for (int i = 1; i < RL; i++) rq[i] <= rq[i-1];
  end
  assign bram_rd_data = rq[RL-1];

  // Reference model: word contents, per-address last accept, pending writes.
  typedef struct {
    int            c;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           wq [$];
  logic [DW-1:0] ref_mem [DEPTH];
  int            last_acc [DEPTH];
  logic          chk_ready = 1'b0;
  int            sw_cnt = 0;
  int            sw_total = 0;
  int            done_cnt = 0;
  int            wr_cnt = 0;
  int            first_out = 0;
  int            last_out = 0;
  logic [DW-1:0] nv;
  logic          exp_rdy;

  initial begin
    for (int i = 0; i < DEPTH; i++) last_acc[i] = -100;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      wq.delete();
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = mem[i];
      sw_cnt = 0;
    end else begin
      if (clr) for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      if (pre_en) ref_mem[pre_addr] = pre_data;
      if (chk_ready) begin
        exp_rdy = (cyc - last_acc[upd_addr]) > (RL + 1);
        check("upd_ready_model", 64'(upd_ready), 64'(exp_rdy));
      end
      if (upd_valid && upd_ready) begin
        check("issue_rd_en", 64'(bram_rd_en), 64'd1);
        check("issue_rd_addr", 64'(bram_rd_addr), 64'(upd_addr));
        if (ref_mem[upd_addr] > MAXV - upd_value) nv = MAXV;
        else nv = ref_mem[upd_addr] + upd_value;
        wq.push_back('{cyc + RL + 1, upd_addr, nv});
        ref_mem[upd_addr] = nv;
        last_acc[upd_addr] = cyc;
      end
      if (wq.size() > 0 && wq[0].c < cyc) begin
        check("wr_missing", 64'(wq[0].c), 64'(cyc));
        void'(wq.pop_front());
      end
      if (out_valid) begin
        check("sweep_addr", 64'(out_addr), 64'(sw_cnt));
        check("sweep_value", 64'(out_value), 64'(ref_mem[out_addr]));
        check("sweep_wr_en", 64'(bram_wr_en), 64'd1);
        check("sweep_wr_addr", 64'(bram_wr_addr), 64'(out_addr));
        check("sweep_wr_zero", 64'(bram_wr_data), 64'd0);
        ref_mem[out_addr] = '0;
        if (sw_cnt == 0) first_out = cyc;
        last_out = cyc;
        sw_cnt++;
      end else if (bram_wr_en) begin
        if (wq.size() == 0 || wq[0].c != cyc) begin
          check("wr_unexpected", 64'(bram_wr_addr), 64'hdead);
        end else begin
          check("wr_addr", 64'(bram_wr_addr), 64'(wq[0].a));
          check("wr_data", 64'(bram_wr_data), 64'(wq[0].d));
          void'(wq.pop_front());
        end
      end
      if (bram_wr_en) wr_cnt++;
      if (sweep_done) begin
        done_cnt++;
        sw_total = sw_cnt;
        sw_cnt = 0;
      end
    end
  end

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] pre;
    logic [DW-1:0] v;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t vecs [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] v);
    pre_en = 1'b1;
    pre_addr = a;
    pre_data = v;
    tick();
    pre_en = 1'b0;
  endtask

  task automatic idle(input int n);
    upd_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  int  snap;
  int  dsnap;
  int  r;
  logic seen;

  initial begin
    vecs[0] = '{4'd5, 36'd0, 36'd3, 36'd3};
    vecs[1] = '{4'd9, MAXV - 36'd1, 36'd5, MAXV};
    vecs[2] = '{4'd1, 36'd100, 36'd0, 36'd100};
    vecs[3] = '{4'd2, MAXV, 36'd0, MAXV};
    vecs[4] = '{4'd3, MAXV, MAXV, MAXV};
    vecs[5] = '{4'd4, 36'h8_0000_0000, 36'h8_0000_0000, MAXV};
    vecs[6] = '{4'd6, 36'h7_FFFF_FFFF, 36'h8_0000_0000, MAXV};

    rst_n = 1'b0;
    upd_valid = 1'b0;
    upd_addr = '0;
    upd_value = '0;
    sweep_start = 1'b0;
    clr = 1'b1;
    tick();
    tick();
    clr = 1'b0;
    @(negedge clk);
    check("rst_wr_en", 64'(bram_wr_en), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_done", 64'(sweep_done), 64'd0);
    check("rst_busy", 64'(sweep_busy), 64'd0);
    check("rst_rd_en", 64'(bram_rd_en), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk_ready = 1'b1;

    // Single updates from a table, checked at the exact write cycle.
    foreach (vecs[k]) begin
      preload(vecs[k].a, vecs[k].pre);
      idle(1);
      upd_valid = 1'b1;
      upd_addr = vecs[k].a;
      upd_value = vecs[k].v;
      @(negedge clk);
      check("vec_ready", 64'(upd_ready), 64'd1);
      check("vec_rd_en", 64'(bram_rd_en), 64'd1);
      check("vec_rd_addr", 64'(bram_rd_addr), 64'(vecs[k].a));
      tick();
      upd_valid = 1'b0;
      upd_addr = vecs[k].a ^ 4'd1;
      @(negedge clk);
      check("vec_other_ready", 64'(upd_ready), 64'd1);
      #1;
      upd_addr = vecs[k].a;
      #1;
      check("vec_self_stall", 64'(upd_ready), 64'd0);
      for (int i = 1; i < RL + 1; i++) tick();
      @(negedge clk);
      check("vec_wr_en", 64'(bram_wr_en), 64'd1);
      check("vec_wr_addr", 64'(bram_wr_addr), 64'(vecs[k].a));
      check("vec_wr_data", 64'(bram_wr_data), 64'(vecs[k].exp));
      idle(3);
    end

    // Back-to-back to one address: stall for RD_LAT+1 cycles.
    preload(4'd7, '0);
    idle(1);
    upd_valid = 1'b1;
    upd_addr = 4'd7;
    upd_value = 36'd1;
    tick();
    upd_value = 36'd2;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check("b2b_ready", 64'(upd_ready), (c == 4) ? 64'd1 : 64'd0);
      tick();
    end
    idle(RL + 3);
    check("b2b_word", 64'(mem[7]), 64'd3);

    // Four distinct addresses on consecutive cycles.
    for (int i = 0; i < 4; i++) preload(4'(i), '0);
    idle(1);
    for (int c = 0; c <= 6; c++) begin
      upd_valid = (c < 4);
      upd_addr = 4'(c);
      upd_value = 36'd1;
      @(negedge clk);
      if (c < 4) check("four_ready", 64'(upd_ready), 64'd1);
      if (c >= 3) begin
        check("four_wr_en", 64'(bram_wr_en), 64'd1);
        check("four_wr_addr", 64'(bram_wr_addr), 64'(c - 3));
        check("four_wr_data", 64'(bram_wr_data), 64'd1);
      end
      tick();
    end
    idle(3);

    // Random updates with frequent address conflicts.
    for (int n = 0; n < 400; n++) begin
      upd_valid = ($urandom % 4) != 0;
      upd_addr = 4'($urandom_range(0, 7));
      r = $urandom % 4;
      if (r == 0) upd_value = '0;
      else if (r == 1) upd_value = 36'($urandom_range(1, 50));
      else if (r == 2) upd_value = MAXV - 36'($urandom_range(0, 50));
      else upd_value = {4'($urandom), 32'($urandom)};
      tick();
    end
    idle(RL + 4);
    for (int i = 0; i < DEPTH; i++) check("rand_word", 64'(mem[i]), 64'(ref_mem[i]));
    chk_ready = 1'b0;

    // Sweep with two updates in flight and a held update that must wait.
    for (int i = 0; i < DEPTH; i++) preload(4'(i), 36'(10 + i));
    idle(2);
    dsnap = done_cnt;
    upd_valid = 1'b1;
    upd_addr = 4'd12;
    upd_value = 36'd1;
    tick();
    upd_addr = 4'd13;
    upd_value = 36'd2;
    tick();
    upd_addr = 4'd5;
    upd_value = 36'd7;
    sweep_start = 1'b1;
    @(negedge clk);
    check("sweep_wins", 64'(upd_ready), 64'd0);
    tick();
    sweep_start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (sweep_done) begin
        seen = 1'b1;
        check("done_busy_low", 64'(sweep_busy), 64'd0);
        check("done_ready", 64'(upd_ready), 64'd1);
      end else begin
        check("sweep_stall", 64'(upd_ready), 64'd0);
        check("sweep_busy", 64'(sweep_busy), 64'd1);
      end
      tick();
    end
    check("sweep_done_seen", 64'(seen), 64'd1);
    idle(RL + 4);
    check("sweep_count", 64'(sw_total), 64'(DEPTH));
    check("sweep_consec", 64'(last_out - first_out), 64'(DEPTH - 1));
    check("done_pulses", 64'(done_cnt - dsnap), 64'd1);
    for (int i = 0; i < DEPTH; i++) begin
      check("sweep_cleared", 64'(mem[i]), (i == 5) ? 64'd7 : 64'd0);
    end

    // Reset in the middle of a sweep.
    for (int i = 0; i < DEPTH; i++) preload(4'(i), 36'(100 + i));
    idle(1);
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (bram_rd_en && bram_rd_addr == 4'd4) seen = 1'b1;
    end
    check("mid_addr4_seen", 64'(seen), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    snap = wr_cnt;
    check("mid_wr_en", 64'(bram_wr_en), 64'd0);
    check("mid_out_valid", 64'(out_valid), 64'd0);
    check("mid_busy", 64'(sweep_busy), 64'd0);
    check("mid_rd_en", 64'(bram_rd_en), 64'd0);
    check("mid_done", 64'(sweep_done), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    upd_addr = 4'd4;
    idle(20);
    @(negedge clk);
    check("mid_no_writes", 64'(wr_cnt - snap), 64'd0);
    check("mid_idle", 64'(sweep_busy), 64'd0);
    check("mid_ready", 64'(upd_ready), 64'd1);
    check("mid_word9", 64'(mem[9]), 64'd109);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
